// File: rtl/fetch_pc_ctrl.sv
// Instruction-fetch PC sequencer.
// Owns the architectural PC and gates fetch on start, stall and imem_ready.
// Accepts EX-stage redirects and raises a multi-cycle flush so the wrong-path
// instructions already in IF/ID are killed.
// Outputs are registered, or are a direct decode of a register (flush_o).
module fetch_pc_ctrl #(
  parameter int unsigned          INST_WIDTH   = 32,
  parameter logic [INST_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned          FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [INST_WIDTH-1:0] redirect_pc,
  input  logic                  imem_ready,
  output logic [INST_WIDTH-1:0] pc_o,
  output logic                  fetch_valid,
  output logic                  flush_o,
  output logic                  misalign_err,
  output logic [15:0]           redirect_cnt
);

  // A 3-bit counter covers the supported flush lengths of 1..7 cycles.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [INST_WIDTH-1:0] PC_STEP = INST_WIDTH'(4);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [INST_WIDTH-1:0] pc_next;
  logic [2:0]            flush_cnt;
  logic                  redirect_take;
  logic                  advance;

  // IDLE only exists between reset and the first start; redirects are ignored
  // there so the first fetch after reset is always RESET_PC.
  assign redirect_take = redirect_valid && (state != ST_IDLE);

  // Sequential fetch only advances when the memory accepted the fetch just
  // presented and the hazard unit is not holding the front end.
  assign advance = (state == ST_RUN) && !stall && imem_ready;

  // Next-state and next-PC selection; redirect beats sequential advance.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_next = state;
    pc_next    = pc_o;

    case (state)
      ST_IDLE: if (start)  state_next = ST_RUN;
      ST_RUN:  if (!start) state_next = ST_HALT;
      ST_HALT: if (start)  state_next = ST_RUN;
      default:             state_next = ST_IDLE;
    endcase

    if (redirect_take) begin
      // Targets are forced to word alignment; misalignment is only reported.
      pc_next = {redirect_pc[INST_WIDTH-1:2], 2'b00};
    end else if (advance) begin
      // Natural modulo-2^INST_WIDTH wrap at the top of the address space.
      pc_next = pc_o + PC_STEP;
    end
  end

  // State, PC and fetch-valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc_o        <= RESET_PC;
      fetch_valid <= 1'b0;
    end else begin
      state       <= state_next;
      pc_o        <= pc_next;
      fetch_valid <= (state_next == ST_RUN);
    end
  end

  // Flush window: reload on every accepted redirect, otherwise count down
  // once per cycle independent of state, stall and imem_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= 3'd0;
    end else if (redirect_take) begin
      flush_cnt <= FLUSH_LOAD;
    end else if (flush_cnt != 3'd0) begin
      flush_cnt <= flush_cnt - 3'd1;
    end
  end

  assign flush_o = (flush_cnt != 3'd0);

  // One-cycle misalignment pulse for an accepted redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect_take && (redirect_pc[1:0] != 2'b00);
    end
  end

  // Saturating count of accepted redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt <= 16'd0;
    end else if (redirect_take && (redirect_cnt != 16'hFFFF)) begin
      redirect_cnt <= redirect_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed testbench for fetch_pc_ctrl with hand-computed expectations.
module tb_fetch_pc_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_ready;
  logic [31:0] pc_o;
  logic        fetch_valid;
  logic        flush_o;
  logic        misalign_err;
  logic [15:0] redirect_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_pc_ctrl #(
    .INST_WIDTH  (32),
    .RESET_PC    (32'h0000_0000),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_ready    (imem_ready),
    .pc_o          (pc_o),
    .fetch_valid   (fetch_valid),
    .flush_o       (flush_o),
    .misalign_err  (misalign_err),
    .redirect_cnt  (redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compare every output against one expected vector.
  task automatic expect_out(input string tag, input logic [31:0] pc, input logic fv,
                            input logic fl, input logic mis, input logic [15:0] cnt);
    check({tag, ".pc"},    pc_o,                 pc);
    check({tag, ".fv"},    {31'd0, fetch_valid}, {31'd0, fv});
    check({tag, ".flush"}, {31'd0, flush_o},     {31'd0, fl});
    check({tag, ".mis"},   {31'd0, misalign_err}, {31'd0, mis});
    check({tag, ".cnt"},   {16'd0, redirect_cnt}, {16'd0, cnt});
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic v, input logic [31:0] target);
    redirect_valid = v;
    redirect_pc    = target;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; imem_ready = 1'b1;
    redir(1'b0, 32'h0);
    #12;
    expect_out("reset", 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
    rst_n = 1'b1;

    // IDLE holds and ignores redirects.
    tick();
    expect_out("idle", 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
    redir(1'b1, 32'h500);
    tick();
    expect_out("idle_redir", 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
    redir(1'b0, 32'h0);

    // Start and sequential fetch.
    start = 1'b1;
    tick(); expect_out("run0", 32'h0,  1'b1, 1'b0, 1'b0, 16'd0);
    tick(); expect_out("run1", 32'h4,  1'b1, 1'b0, 1'b0, 16'd0);
    tick(); expect_out("run2", 32'h8,  1'b1, 1'b0, 1'b0, 16'd0);
    tick(); expect_out("run3", 32'hC,  1'b1, 1'b0, 1'b0, 16'd0);
    tick(); expect_out("run4", 32'h10, 1'b1, 1'b0, 1'b0, 16'd0);

    // Redirect under stall; flush lasts exactly two cycles.
    stall = 1'b1; redir(1'b1, 32'h100);
    tick(); expect_out("rd1_a", 32'h100, 1'b1, 1'b1, 1'b0, 16'd1);
    redir(1'b0, 32'h0);
    tick(); expect_out("rd1_b", 32'h100, 1'b1, 1'b1, 1'b0, 16'd1);
    tick(); expect_out("rd1_c", 32'h100, 1'b1, 1'b0, 1'b0, 16'd1);

    // Misaligned redirect, then back-to-back redirect restarting the window.
    stall = 1'b0; redir(1'b1, 32'h203);
    tick(); expect_out("mis_a", 32'h200, 1'b1, 1'b1, 1'b1, 16'd2);
    redir(1'b1, 32'h300);
    tick(); expect_out("mis_b", 32'h300, 1'b1, 1'b1, 1'b0, 16'd3);
    stall = 1'b1; redir(1'b0, 32'h0);
    tick(); expect_out("mis_c", 32'h300, 1'b1, 1'b1, 1'b0, 16'd3);
    tick(); expect_out("mis_d", 32'h300, 1'b1, 1'b0, 1'b0, 16'd3);

    // imem_ready low holds the PC with fetch still valid.
    stall = 1'b0; imem_ready = 1'b0; redir(1'b1, 32'h40);
    tick(); expect_out("rdy_a", 32'h40, 1'b1, 1'b1, 1'b0, 16'd4);
    redir(1'b0, 32'h0);
    tick(); expect_out("rdy_b", 32'h40, 1'b1, 1'b1, 1'b0, 16'd4);
    tick(); expect_out("rdy_c", 32'h40, 1'b1, 1'b0, 1'b0, 16'd4);
    tick(); expect_out("rdy_d", 32'h40, 1'b1, 1'b0, 1'b0, 16'd4);
    imem_ready = 1'b1;
    tick(); expect_out("rdy_e", 32'h44, 1'b1, 1'b0, 1'b0, 16'd4);

    // Halt together with a redirect; resume from the held PC.
    start = 1'b0; redir(1'b1, 32'h80);
    tick(); expect_out("halt_a", 32'h80, 1'b0, 1'b1, 1'b0, 16'd5);
    redir(1'b0, 32'h0);
    tick(); expect_out("halt_b", 32'h80, 1'b0, 1'b1, 1'b0, 16'd5);
    tick(); expect_out("halt_c", 32'h80, 1'b0, 1'b0, 1'b0, 16'd5);
    start = 1'b1;
    tick(); expect_out("resume_a", 32'h80, 1'b1, 1'b0, 1'b0, 16'd5);
    tick(); expect_out("resume_b", 32'h84, 1'b1, 1'b0, 1'b0, 16'd5);

    // Top-of-address-space wrap (misaligned target also forces alignment).
    redir(1'b1, 32'hFFFF_FFFF);
    tick(); expect_out("wrap_a", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1, 16'd6);
    redir(1'b0, 32'h0);
    tick(); expect_out("wrap_b", 32'h0, 1'b1, 1'b1, 1'b0, 16'd6);
    redir(1'b1, 32'h10);
    tick(); expect_out("pre_rst", 32'h10, 1'b1, 1'b1, 1'b0, 16'd7);
    redir(1'b0, 32'h0);

    // Asynchronous reset mid-flush, between clock edges.
    #2 rst_n = 1'b0;
    #1 expect_out("async_rst", 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); expect_out("post_rst_a", 32'h0, 1'b1, 1'b0, 1'b0, 16'd0);
    tick(); expect_out("post_rst_b", 32'h4, 1'b1, 1'b0, 1'b0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
